// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to complete MULT/MULTU in a single cycle (divides stay iterative).
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic        hilo_readD,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_req
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        is_div_q;
    logic        dz_q;
    logic        neg_lo_q;
    logic        neg_hi_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        div_zero;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & srcA[31];
        b_neg     = is_signed & srcB[31];
        a_abs     = a_neg ? (~srcA + 32'd1) : srcA;
        b_abs     = b_neg ? (~srcB + 32'd1) : srcB;
        div_zero  = op[1] & (srcB == 32'd0);
    end

    // One radix-2 step for each algorithm; acc_q holds {partial, multiplier} or {rem, quot}.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_tmp;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        div_tmp  = acc_q[63:31];
        div_ge   = div_tmp >= {1'b0, opnd_q};
        div_diff = div_tmp - {1'b0, opnd_q};
        div_next = div_ge ? {div_diff[31:0], acc_q[30:0], 1'b1}
                          : {div_tmp[31:0], acc_q[30:0], 1'b0};
    end

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    always_comb begin
        prod_fix = neg_lo_q ? (~acc_q + 64'd1) : acc_q;
        quot_fix = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (dz_q) begin
            fix_hi = acc_q[63:32];
            fix_lo = acc_q[31:0];
        end else if (is_div_q) begin
            fix_hi = rem_fix;
            fix_lo = quot_fix;
        end else begin
            fix_hi = prod_fix[63:32];
            fix_lo = prod_fix[31:0];
        end
    end

    logic        fast_mul;
    logic [63:0] fast_prod;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    always_comb begin
        ext_a     = {{32{is_signed & srcA[31]}}, srcA};
        ext_b     = {{32{is_signed & srcB[31]}}, srcB};
        // Low 64 bits of the extended product are exact for both signed and unsigned.
        fast_prod = ext_a * ext_b;
        fast_mul  = ~op[1];
    end
`else
    assign fast_mul  = 1'b0;
    assign fast_prod = 64'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && fast_mul) begin
                            hi_q   <= fast_prod[63:32];
                            lo_q   <= fast_prod[31:0];
                            done_q <= 1'b1;
                        end else if (start) begin
                            state_q  <= div_zero ? StFix : StCalc;
                            cnt_q    <= 5'd0;
                            is_div_q <= op[1];
                            dz_q     <= div_zero;
                            neg_lo_q <= a_neg ^ b_neg;
                            neg_hi_q <= a_neg;
                            if (div_zero) begin
                                acc_q <= {srcA, 32'hFFFF_FFFF};
                            end else if (op[1]) begin
                                acc_q  <= {32'd0, a_abs};
                                opnd_q <= b_abs;
                            end else begin
                                acc_q  <= {32'd0, b_abs};
                                opnd_q <= a_abs;
                            end
                        end else begin
                            if (hi_we) hi_q <= srcA;
                            if (lo_we) lo_q <= srcA;
                        end
                    end
                    StCalc: begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        if (cnt_q == 5'd31) begin
                            state_q <= StFix;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    StFix: begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign stall_req = busy & (hilo_readD | start | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, corner sequences and random ops vs. a model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        hilo_readD = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall_req;

    int checks = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .srcA       (srcA),
        .srcB       (srcB),
        .flush      (flush),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hilo_readD (hilo_readD),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural meaning of each op.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin q = sa * sb; p = q; end
            2'b01: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        return p;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        if (o[1]) return (b == 32'd0) ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
        return 0;
`else
        return 33;
`endif
    endfunction

    // Called at the negedge after the start edge; k counts edges after t until done is seen.
    task automatic wait_done(output int k, output int busy_cnt, output logic [63:0] res);
        k = 0;
        busy_cnt = 0;
        while (!done && k < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
        res = {hi, lo};
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        srcA = a;
        srcB = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        srcA = $urandom;
        srcB = $urandom;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, output int busy_cnt);
        int k;
        logic [63:0] res;
        issue(o, a, b);
        wait_done(k, busy_cnt, res);
        chk({name, ".result"}, res, exp);
        chk({name, ".latency"}, 64'(k), 64'(exp_lat(o, b)));
        @(negedge clk);
        chk({name, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int bc;
        int k;
        int done_seen;
        logic [63:0] res;

        vecs[0] = '{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{"div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[2] = '{"divu_by0", 2'b11, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF};
        vecs[3] = '{"div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[4] = '{"mult_3_m4", 2'b00, 32'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4};
        vecs[5] = '{"divu_7_2", 2'b11, 32'd7, 32'd2, 64'h0000_0001_0000_0003};
        vecs[6] = '{"mult_m1_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[7] = '{"div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[8] = '{"div_by0_neg", 2'b10, 32'h8000_0000, 32'd0, 64'h8000_0000_FFFF_FFFF};
        vecs[9] = '{"multu_2p16", 2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

        // Reset state
        #3;
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].name, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp, bc);
            if (i == 1) chk("div_m7_2.busy_cycles", 64'(bc), 64'd33);
        end

        // MTHI / MTLO from idle
        srcA = 32'hAAAA_5555;
        hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        srcA = 32'h1234_5678;
        lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi_mtlo", {hi, lo}, 64'hAAAA_5555_1234_5678);

        // Stall request while idle vs. busy; flush mid-CALC
        hilo_readD = 1'b1;
        #1 chk("stall.idle", 64'(stall_req), 64'd0);
        issue(2'b10, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        chk("stall.busy", 64'(stall_req), 64'd1);
        hilo_readD = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush.busy", 64'(busy), 64'd0);
        chk("flush.hilo", {hi, lo}, 64'hAAAA_5555_1234_5678);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("flush.no_done", 64'(done_seen), 64'd0);

        // Flush and start at the same edge: start discarded
        op = 2'b00;
        srcA = 32'd5;
        srcB = 32'd6;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start.busy", 64'(busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("flush_start.no_done", 64'(done_seen), 64'd0);
        chk("flush_start.hilo", {hi, lo}, 64'hAAAA_5555_1234_5678);

        // Start while busy is ignored; MTHI while busy does not land
        issue(2'b11, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        op = 2'b01;
        srcA = 32'd5;
        srcB = 32'd6;
        start = 1'b1;
        hi_we = 1'b1;
        #1 chk("busy_start.stall", 64'(stall_req), 64'd1);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        wait_done(k, bc, res);
        chk("busy_start.result", res, 64'h0000_0002_0000_000E);
        chk("busy_start.latency", 64'(k + 6), 64'd33);
        @(negedge clk);

        // Async reset mid-CALC, then a fresh MULT
        issue(2'b10, 32'd12345, 32'd17);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.hilo", {hi, lo}, 64'd0);
        chk("areset.busy", 64'(busy), 64'd0);
        chk("areset.done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst_mult", 2'b00, 32'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, bc);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ref_op(ro, ra, rb), bc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
